// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the BCD-to-binary converter:
//   - bcd_state_t : FSM state encoding for bcd_bin (IDLE=0, SHIFT=1)
//   - DIGITS_DEF  : default number of packed BCD digits
//   - BIN_W_DEF   : default binary result width
//   - ADJ_THRESH  : nibble value at or above which the correction applies
//   - ADJ_CORR    : correction subtracted from an adjusted nibble
// ---------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bcd_state_t;

    localparam int DIGITS_DEF = 4;
    localparam int BIN_W_DEF  = 14;

    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_CORR   = 4'd3;

endpackage

// File: rtl/bcd_adj.sv
// ---------------------------------------------------------------------------
// bcd_adj
// Combinational nibble correction used after each right shift of the BCD
// register: a nibble of 8 or more has just received a carried-in bit worth
// 8 that really represents 10/2 = 5, so 3 is subtracted.
// Ports:
//   nib_i : 4-bit nibble after the shift
//   nib_o : corrected nibble
// ---------------------------------------------------------------------------
module bcd_adj
    import calc_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    // Subtract the correction when the nibble reaches the threshold.
    always_comb begin
        if (nib_i >= ADJ_THRESH) begin
            nib_o = nib_i - ADJ_CORR;
        end else begin
            nib_o = nib_i;
        end
    end

endmodule

// File: rtl/bcd_bin.sv
// ---------------------------------------------------------------------------
// bcd_bin
// Sequential packed-BCD to binary converter using reverse double dabble:
// one shift/adjust step per clock, 4*DIGITS steps per conversion.
// Optional input checking is enabled by defining BCD_BIN_CHECK_EN: a
// request containing a nibble > 9 then completes one cycle after capture
// with err=1 and bin_out=0. Without the macro err is always 0.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   start   : conversion request, sampled only while idle
//   bcd_in  : packed BCD input, digit 0 in bits [3:0]
//   busy    : conversion in progress
//   rdy     : one-cycle pulse, bin_out/err valid
//   bin_out : binary result, held until the next rdy
//   err     : invalid digit flag, held until the next rdy
// ---------------------------------------------------------------------------
module bcd_bin #(
    parameter int DIGITS = calc_pkg::DIGITS_DEF,
    parameter int BIN_W  = calc_pkg::BIN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  rdy,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);
    import calc_pkg::*;

    localparam int SH_W  = 4 * DIGITS;
    localparam int CNT_W = (SH_W > 1) ? $clog2(SH_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SH_W - 1);

    bcd_state_t        state_q, state_d;
    logic [SH_W-1:0]   bcd_q, bcd_d;
    logic [SH_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              rdy_q, rdy_d;
    logic [BIN_W-1:0]  bin_out_q, bin_out_d;
    logic              err_q, err_d;
    logic              inv_s;
    logic              inv_d;

    logic [SH_W-1:0]   bcd_sh_s;
    logic [SH_W-1:0]   bcd_adj_s;
    logic [SH_W-1:0]   bin_sh_s;

    // Shift {bcd, bin} right by one; the BCD LSB enters the binary MSB.
    assign bcd_sh_s = {1'b0, bcd_q[SH_W-1:1]};
    assign bin_sh_s = {bcd_q[0], bin_q[SH_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adj u_adj (
            .nib_i (bcd_sh_s[4*g +: 4]),
            .nib_o (bcd_adj_s[4*g +: 4])
        );
    end

`ifdef BCD_BIN_CHECK_EN
    logic inv_q;
    logic any_bad_s;

    // Flag any nibble of the incoming request that is not a decimal digit.
    always_comb begin
        any_bad_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            any_bad_s = any_bad_s | (bcd_in[4*i +: 4] > 4'd9);
        end
    end

    // Hold the invalid-request flag for the single cycle spent in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end

    assign inv_s = inv_q;
`else
    logic any_bad_s;
    assign any_bad_s = 1'b0;
    assign inv_s     = 1'b0;
`endif

    // Next-state and datapath logic for the capture / shift / finish sequence.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        rdy_d     = 1'b0;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        inv_d     = inv_s;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    bcd_d   = bcd_in;
                    bin_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    inv_d   = any_bad_s;
                end else begin
                    inv_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (inv_s) begin
                    // Invalid request: report immediately, no shifting.
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    rdy_d     = 1'b1;
                    bin_out_d = '0;
                    err_d     = 1'b1;
                    inv_d     = 1'b0;
                end else begin
                    bcd_d = bcd_adj_s;
                    bin_d = bin_sh_s;
                    if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        rdy_d     = 1'b1;
                        bin_out_d = BIN_W'(bin_sh_s);
                        err_d     = 1'b0;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                inv_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end

    assign busy    = busy_q;
    assign rdy     = rdy_q;
    assign bin_out = bin_out_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd_bin
// Directed self-checking bench for bcd_bin (DIGITS=4, BIN_W=14).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_bin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        rdy;
    logic [13:0] bin_out;
    logic        err;

    int n_assert;
    int n_fail;

    bcd_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .rdy     (rdy),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start; returns at the falling edge after capture.
    task automatic launch(input logic [15:0] v);
        bcd_in = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Count falling edges until rdy is seen (0 on timeout); held reports
    // whether bin_out/err stayed unchanged before the rdy pulse.
    task automatic wait_rdy(output int cyc, output logic held);
        logic [13:0] ref_b;
        logic        ref_e;
        ref_b = bin_out;
        ref_e = err;
        held  = 1'b1;
        cyc   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                cyc = i;
                break;
            end
            if (bin_out !== ref_b || err !== ref_e) held = 1'b0;
        end
    endtask

    initial begin
        int   cyc;
        logic held;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        bcd_in   = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy",  32'(rdy),  32'd0);
        chk("rst_bin",  32'(bin_out), 32'd0);
        chk("rst_err",  32'(err),  32'd0);

        // All nines: maximum value, 16-cycle latency
        launch(16'h9999);
        chk("9999_busy", 32'(busy), 32'd1);
        wait_rdy(cyc, held);
        chk("9999_lat",  32'(cyc + 1), 32'd17);
        chk("9999_hold", 32'(held), 32'd1);
        chk("9999_bin",  32'(bin_out), 32'd9999);
        chk("9999_err",  32'(err), 32'd0);
        chk("9999_busy_end", 32'(busy), 32'd0);
        @(negedge clk);
        chk("9999_rdy_pulse", 32'(rdy), 32'd0);
        chk("9999_bin_held",  32'(bin_out), 32'd9999);

        launch(16'h0000);
        wait_rdy(cyc, held);
        chk("0000_lat", 32'(cyc), 32'd16);
        chk("0000_bin", 32'(bin_out), 32'd0);

        launch(16'h0255);
        wait_rdy(cyc, held);
        chk("0255_lat", 32'(cyc), 32'd16);
        chk("0255_bin", 32'(bin_out), 32'd255);

        launch(16'h1000);
        wait_rdy(cyc, held);
        chk("1000_lat", 32'(cyc), 32'd16);
        chk("1000_bin", 32'(bin_out), 32'd1000);
        @(negedge clk);

        // Start while busy is ignored; start on the rdy cycle is accepted
        launch(16'h0042);
        repeat (4) @(negedge clk);
        bcd_in = 16'h0077;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'h0000;
        wait_rdy(cyc, held);
        chk("busy_ign_lat",  32'(cyc), 32'd11);
        chk("busy_ign_hold", 32'(held), 32'd1);
        chk("busy_ign_bin",  32'(bin_out), 32'd42);
        launch(16'h0077);
        wait_rdy(cyc, held);
        chk("b2b_lat",  32'(cyc), 32'd16);
        chk("b2b_hold", 32'(held), 32'd1);
        chk("b2b_bin",  32'(bin_out), 32'd77);
        @(negedge clk);

        // Reset mid-conversion aborts without rdy
        launch(16'h1234);
        repeat (7) @(negedge clk);
        chk("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdy",  32'(rdy),  32'd0);
        chk("abort_bin",  32'(bin_out), 32'd0);
        chk("abort_err",  32'(err),  32'd0);
        launch(16'h0010);
        wait_rdy(cyc, held);
        chk("post_rst_lat",  32'(cyc), 32'd16);
        chk("post_rst_hold", 32'(held), 32'd1);
        chk("post_rst_bin",  32'(bin_out), 32'd10);
        @(negedge clk);

        // Start held high restarts on every idle cycle with fresh input
        bcd_in = 16'h0031;
        start  = 1'b1;
        wait_rdy(cyc, held);
        chk("held_lat1", 32'(cyc), 32'd17);
        chk("held_bin1", 32'(bin_out), 32'd31);
        bcd_in = 16'h0064;
        wait_rdy(cyc, held);
        chk("held_lat2", 32'(cyc), 32'd17);
        chk("held_bin2", 32'(bin_out), 32'd64);
        start  = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_idle", 32'(busy), 32'd0);

`ifdef BCD_BIN_CHECK_EN
        // Invalid digit reported one cycle after capture
        launch(16'h12A4);
        chk("inv_rdy0", 32'(rdy), 32'd0);
        wait_rdy(cyc, held);
        chk("inv_lat",  32'(cyc), 32'd1);
        chk("inv_err",  32'(err), 32'd1);
        chk("inv_bin",  32'(bin_out), 32'd0);
        chk("inv_busy", 32'(busy), 32'd0);
        @(negedge clk);
        launch(16'h0005);
        wait_rdy(cyc, held);
        chk("val_lat", 32'(cyc), 32'd16);
        chk("val_err", 32'(err), 32'd0);
        chk("val_bin", 32'(bin_out), 32'd5);
`else
        // Unchecked build: invalid top digit converts as 10*1000 + 123
        launch(16'hA123);
        wait_rdy(cyc, held);
        chk("unchk_lat", 32'(cyc), 32'd16);
        chk("unchk_bin", 32'(bin_out), 32'd10123);
        chk("unchk_err", 32'(err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_bin.md
BCD_BIN -- requirements
Module: bcd_bin

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of packed BCD input digits.
REQ-002 SHALL have parameter BIN_W, default 14: binary result width; SHALL satisfy 2^BIN_W > 10^DIGITS-1.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a conversion; sampled only in IDLE.
REQ-006 bcd_in  input  4*DIGITS  packed BCD value; digit 0 is bits [3:0].
REQ-007 busy  output  1  conversion in progress.
REQ-008 rdy  output  1  one-cycle pulse: bin_out and err are valid.
REQ-009 bin_out  output  BIN_W  binary result; held until the next rdy.
REQ-010 err  output  1  invalid digit seen; held until the next rdy.

Function
REQ-011 SHALL implement an FSM with states IDLE and SHIFT.
- IDLE->SHIFT on start.
- SHIFT->IDLE after the last shift.
REQ-012 SHALL capture bcd_in into a working BCD register on edge N when in IDLE with start=1, clear the binary register, zero a shift counter, and assert busy from that edge.
REQ-013 SHALL perform one reverse-double-dabble step on each of edges N+1..N+4*DIGITS:
- shift {bcd, bin} right by 1, with the bcd LSB entering the bin MSB;
- then, for every BCD nibble >= 8, subtract 3 from that nibble.
REQ-014 SHALL, on edge N+4*DIGITS:
- load bin_out with the low BIN_W bits of the shifted binary register;
- set rdy=1 for exactly one cycle;
- clear busy;
- return to IDLE.
REQ-015 latency: rdy high during the cycle after edge N+4*DIGITS (16 cycles after start for DIGITS=4).
REQ-016 start while busy=1 SHALL be ignored, with no queueing and no effect on the running conversion.
REQ-017 start in the same cycle rdy=1 SHALL be accepted (FSM already IDLE), giving back-to-back throughput of one result per 4*DIGITS+1 cycles.
REQ-018 start held high continuously SHALL restart a conversion on every IDLE cycle, capturing bcd_in anew each time.
REQ-019 bin_out and err SHALL change only on the edge that raises rdy.
REQ-020 The arithmetic SHALL be unsigned with no overflow; the maximum input all-9s SHALL give 10^DIGITS-1 exactly.

Reset
REQ-021 rst=1 at any edge SHALL force IDLE, busy=0, rdy=0, bin_out=0, err=0, counter=0, and working registers=0.
REQ-022 rst mid-conversion SHALL abort the conversion without a rdy pulse; start in the first cycle after rst is released SHALL be accepted.

Configuration
REQ-023 Macro BCD_BIN_CHECK_EN.
- Defined: at capture, if any nibble of bcd_in > 9, the block SHALL skip SHIFT and, on edge N+1, pulse rdy with err=1, bin_out=0 and busy deasserted.
- Undefined: err SHALL be tied 0, and invalid nibbles SHALL be converted by the same algorithm with deterministic, unchecked results.

Structure
REQ-024 Package calc_pkg SHALL hold:
- the bcd_bin state encoding (IDLE=0, SHIFT=1);
- the DIGITS/BIN_W defaults;
- the nibble-adjust constants (threshold 8, correction 3).
REQ-025 SHALL instantiate DIGITS copies of combinational sub-module bcd_adj (4-bit in: if >= 8 then subtract 3); all other logic stays in bcd_bin.

Verification
REQ-026 bcd_in=16'h9999, start 1 cycle -> rdy exactly 16 cycles later, bin_out=14'd9999 (0x270F), err=0.
REQ-027 bcd_in=16'h0000 -> bin_out=0; bcd_in=16'h0255 -> bin_out=255; bcd_in=16'h1000 -> bin_out=1000.
REQ-028 start 16'h0042, then start 16'h0077 five cycles later -> one rdy only, bin_out=42; a new start on the rdy cycle with 16'h0077 -> 77 sixteen cycles later.
REQ-029 start 16'h1234, rst at cycle 8 -> no rdy, all outputs 0; start 16'h0010 next cycle -> bin_out=10.
REQ-030 With BCD_BIN_CHECK_EN, bcd_in=16'h12A4 -> rdy 1 cycle after start, err=1, bin_out=0; a following valid 16'h0005 -> err=0, bin_out=5.
